// File: rtl/upower_pkg.sv
// Shared definitions for the uPOWER control path: opcodes, FSM states, instruction classes.
package upower_pkg;

  localparam logic [5:0] OP_XO   = 6'd31;
  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_LWZ  = 6'd32;
  localparam logic [5:0] OP_LBZ  = 6'd34;
  localparam logic [5:0] OP_LHZ  = 6'd40;
  localparam logic [5:0] OP_LHA  = 6'd42;
  localparam logic [5:0] OP_STW  = 6'd36;
  localparam logic [5:0] OP_B    = 6'd18;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsIllegal
  } iclass_e;

  // Map a primary opcode onto the class that selects the sequencer's path.
  function automatic iclass_e classify(input logic [5:0] op);
    iclass_e cls;
    case (op)
      OP_XO, OP_ADDI:                 cls = ClsAlu;
      OP_LWZ, OP_LBZ, OP_LHZ, OP_LHA: cls = ClsLoad;
      OP_STW:                         cls = ClsStore;
      OP_B:                           cls = ClsBranch;
      default:                        cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/upower_instr_decode.sv
// Combinational field extraction and classification of a latched instruction word.
module upower_instr_decode
  import upower_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [9:0]  xo,
  output logic [63:0] imm,
  output iclass_e     iclass
);

  // Fields are numbered MSB-first in the ISA; these are the LSB-0 equivalents.
  always_comb begin
    opcode = ir[31:26];
    rd     = ir[25:21];
    rs     = ir[20:16];
    rt     = ir[15:11];
    xo     = ir[10:1];
    imm    = {{48{ir[15]}}, ir[15:0]};
    iclass = classify(ir[31:26]);
  end

endmodule

// File: rtl/upower_ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the uPOWER datapath.
module upower_ctrl_sequencer
  import upower_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  input  logic            dmem_ack,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [5:0]      opcode,
  output logic [9:0]      xo,
  output logic [63:0]     imm,
  output logic            RegRead,
  output logic            RegWrite,
  output logic [PC_W-1:0] pc,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   ipc_q, ipc_d;
  logic [31:0]       ir_q, ir_d;
  logic              illegal_q, illegal_d;
  iclass_e           iclass;
  logic signed [25:0] li;
  logic [PC_W-1:0]   br_off;

  upower_instr_decode u_decode (
    .ir     (ir_q),
    .opcode (opcode),
    .rd     (rd),
    .rs     (rs),
    .rt     (rt),
    .xo     (xo),
    .imm    (imm),
    .iclass (iclass)
  );

  // Branch displacement; the size cast sign-extends or truncates to any PC width.
  assign li     = {ir_q[25:2], 2'b00};
  assign br_off = PC_W'(li);

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign illegal   = illegal_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ipc_q     <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ipc_q     <= ipc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ipc_d     = ipc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    RegRead   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;

    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          ipc_d   = pc_q;
          pc_d    = pc_q + PC_W'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        RegRead = 1'b1;
        if (iclass == ClsIllegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (iclass)
          ClsBranch: begin
            pc_d    = ipc_q + br_off;
            state_d = StFetch;
          end
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        MemRead  = (iclass == ClsLoad);
        MemWrite = (iclass != ClsLoad);
        if (dmem_ack) begin
          state_d = (iclass == ClsLoad) ? StWb : StFetch;
        end
      end
      StWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase

    // Nothing is strobed while reset is held, so an interrupted access never completes.
    if (rst) begin
      imem_req = 1'b0;
      RegRead  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule
